// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Request/acknowledge bus between one SRAM requester and the
//               sram_arbiter. The master side issues req/we/addr/wdata and
//               receives a one-cycle ack with read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 8
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          ack;

   modport master (output req, we, addr, wdata, input  rdata, ack);
   modport slave  (input  req, we, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port arbiter and sequencer for an external asynchronous
//               SRAM. Port A and port B share the SRAM pins; reads take one
//               bus cycle, writes a single registered we_n strobe.
//               Optional macro SRAM_ARB_RR_EN selects round-robin arbitration
//               (default: fixed priority, A over B).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
   parameter int AW = 19,
   parameter int DW = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   sram_arbiter_if.slave      a_port,
   sram_arbiter_if.slave      b_port,
   output logic [AW-1:0]      sram_a,
   inout  wire  [DW-1:0]      sram_d,
   output logic               sram_we_n,
   output logic               busy,
   output logic               owner
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RD    = 2'd1;
   localparam logic [1:0] WR_LO = 2'd2;
   localparam logic [1:0] WR_HI = 2'd3;

   logic [1:0]    r_state;
   logic          r_owner;
   logic [AW-1:0] r_sram_a;
   logic [DW-1:0] r_wdata;
   logic          r_we_n;
   logic          r_a_ack;
   logic          r_b_ack;
   logic [DW-1:0] r_a_rdata;
   logic [DW-1:0] r_b_rdata;

   logic          w_any;
   logic          w_pick_b;
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_done;

   // Arbitration: choose the winning port and mux its transaction fields
   always_comb begin
      w_any = a_port.req | b_port.req;
`ifdef SRAM_ARB_RR_EN
      // On a tie the port that did not own the previous grant wins
      w_pick_b = b_port.req & (~a_port.req | ~r_owner);
`else
      w_pick_b = b_port.req & ~a_port.req;
`endif
      w_we    = w_pick_b ? b_port.we    : a_port.we;
      w_addr  = w_pick_b ? b_port.addr  : a_port.addr;
      w_wdata = w_pick_b ? b_port.wdata : a_port.wdata;
   end

   // A transaction finishes in RD (data captured) or WR_HI (strobe released)
   assign w_done = (r_state == RD) || (r_state == WR_HI);

   // Sequencer: grant in IDLE, then run the read or the write strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_owner  <= 1'b0;
         r_sram_a <= '0;
         r_wdata  <= '0;
         r_we_n   <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_sram_a <= w_addr;
                  r_wdata  <= w_wdata;
                  r_owner  <= w_pick_b;
                  r_state  <= w_we ? WR_LO : RD;
               end
            end
            RD: begin
               r_state <= IDLE;
            end
            WR_LO: begin
               // Address has been stable for a full cycle before the strobe
               r_we_n  <= 1'b0;
               r_state <= WR_HI;
            end
            WR_HI: begin
               r_we_n  <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Completion: one-cycle ack to the owner, read data held until next read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_ack   <= 1'b0;
         r_b_ack   <= 1'b0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_a_ack <= w_done & ~r_owner;
         r_b_ack <= w_done &  r_owner;
         if (r_state == RD) begin
            if (r_owner) begin
               r_b_rdata <= sram_d;
            end else begin
               r_a_rdata <= sram_d;
            end
         end
      end
   end

   // The data pins are driven only during the write strobe cycle
   assign sram_d    = r_we_n ? {DW{1'bz}} : r_wdata;
   assign sram_a    = r_sram_a;
   assign sram_we_n = r_we_n;
   assign busy      = (r_state != IDLE);
   assign owner     = r_owner;

   assign a_port.ack   = r_a_ack;
   assign a_port.rdata = r_a_rdata;
   assign b_port.ack   = r_b_ack;
   assign b_port.rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter with an SRAM model and a
//               transaction-level reference model of grant/ack timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_arbiter_if #(.AW(AW), .DW(DW)) a_bus ();
   sram_arbiter_if #(.AW(AW), .DW(DW)) b_bus ();

   wire  [DW-1:0] sram_d;
   logic [AW-1:0] sram_a;
   logic          sram_we_n;
   logic          busy;
   logic          owner;

   sram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_port    (a_bus),
      .b_port    (b_bus),
      .sram_a    (sram_a),
      .sram_d    (sram_d),
      .sram_we_n (sram_we_n),
      .busy      (busy),
      .owner     (owner)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Power-up contents of the SRAM (also the reference default)
   function automatic logic [7:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
   endfunction

   // ---------------- SRAM model: chip enabled while the arbiter is busy -----
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int we_low_cnt = 0;
   assign sram_d = (busy && sram_we_n) ? mem[sram_a] : {DW{1'bz}};

   // ---------------- reference model ----------------------------------------
   logic [7:0] ref_mem [bit [AW-1:0]];
   int            m_edge, m_free, m_n, m_len;
   logic          m_act, m_port, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd;
   logic          e_ack_a, e_ack_b, e_busy, e_we_n, e_owner;
   logic [AW-1:0] e_sram_a;
   logic [DW-1:0] e_rd_a, e_rd_b;

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   task automatic model_step();
      logic pb;
      if (!rst_n) begin
         m_edge = 0; m_free = 0; m_act = 1'b0; m_n = 0; m_len = 0;
         m_port = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
         e_ack_a = 1'b0; e_ack_b = 1'b0; e_busy = 1'b0; e_we_n = 1'b1;
         e_owner = 1'b0; e_sram_a = '0; e_rd_a = '0; e_rd_b = '0;
      end else begin
         m_edge++;
         e_ack_a = 1'b0;
         e_ack_b = 1'b0;
         // read completes one edge after grant, write two edges after grant
         if (m_act && m_edge == m_n + m_len) begin
            if (m_port) e_ack_b = 1'b1; else e_ack_a = 1'b1;
            if (m_we) ref_mem[m_addr] = m_wd;
            else if (m_port) e_rd_b = ref_rd(m_addr);
            else e_rd_a = ref_rd(m_addr);
            m_act = 1'b0;
         end
         if (!m_act && m_edge >= m_free && (a_bus.req || b_bus.req)) begin
            if (a_bus.req && b_bus.req) begin
`ifdef SRAM_ARB_RR_EN
               pb = ~e_owner;
`else
               pb = 1'b0;
`endif
            end else begin
               pb = b_bus.req;
            end
            m_act  = 1'b1;
            m_port = pb;
            m_n    = m_edge;
            m_we   = pb ? b_bus.we    : a_bus.we;
            m_addr = pb ? b_bus.addr  : a_bus.addr;
            m_wd   = pb ? b_bus.wdata : a_bus.wdata;
            m_len  = m_we ? 2 : 1;
            m_free = m_edge + m_len + 1;
            e_owner  = pb;
            e_sram_a = m_addr;
         end
         e_busy = m_act;
         e_we_n = !(m_act && m_we && m_edge == m_n + 1);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // ---------------- per-cycle checker, ack monitor, SRAM write ------------
   int ackq[$];
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("a_ack",     a_bus.ack,   e_ack_a);
         chk("b_ack",     b_bus.ack,   e_ack_b);
         chk("busy",      busy,        e_busy);
         chk("owner",     owner,       e_owner);
         chk("sram_a",    sram_a,      e_sram_a);
         chk("sram_we_n", sram_we_n,   e_we_n);
         chk("a_rdata",   a_bus.rdata, e_rd_a);
         chk("b_rdata",   b_bus.rdata, e_rd_b);
         if (a_bus.ack) ackq.push_back(0);
         if (b_bus.ack) ackq.push_back(1);
         if (!sram_we_n) begin
            chk("sram_wdata", sram_d, m_wd);
            mem[sram_a] = sram_d;
            we_low_cnt++;
         end
      end
   end

   // ---------------- driver helpers -----------------------------------------
   task automatic drv(input int p, input logic rq, input logic we,
                      input logic [AW-1:0] ad, input logic [DW-1:0] wd);
      if (p == 0) begin
         a_bus.req = rq; a_bus.we = we; a_bus.addr = ad; a_bus.wdata = wd;
      end else begin
         b_bus.req = rq; b_bus.we = we; b_bus.addr = ad; b_bus.wdata = wd;
      end
   endtask

   task automatic drop(input int p);
      if (p == 0) a_bus.req = 1'b0; else b_bus.req = 1'b0;
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? a_bus.ack : b_bus.ack;
   endfunction

   // Called at a negedge right after req is presented; returns at the ack cycle
   task automatic wait_ack(input int p, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!ack_of(p) && lat < 100);
      if (!ack_of(p)) chk($sformatf("ack_timeout_p%0d", p), 0, 1);
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom_range(0, 2))
         0:       return AW'($urandom_range(0, 15));
         1:       return AW'(19'h7FFF0 + $urandom_range(0, 15));
         default: return AW'($urandom);
      endcase
   endfunction

   task automatic run_port(input int p, input int n, input int gap_max, input int wpct);
      int gap;
      int lat;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, gap_max);
         if (gap > 0) begin
            drop(p);
            for (int g = 0; g < gap; g++) begin
               // a one-cycle request while busy can never be granted
               if (busy && $urandom_range(0, 3) == 0) begin
                  drv(p, 1'b1, 1'($urandom), rnd_addr(), 8'($urandom));
                  @(negedge clk);
                  drop(p);
               end else begin
                  @(negedge clk);
               end
            end
         end
         drv(p, 1'b1, ($urandom_range(0, 99) < wpct), rnd_addr(), 8'($urandom));
         wait_ack(p, lat);
      end
      drop(p);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int lat;
      int cnt0;
      int last;
      logic [DW-1:0] exp_b;
      for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
      drv(0, 1'b0, 1'b0, '0, '0);
      drv(1, 1'b0, 1'b0, '0, '0);

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_we_n",    sram_we_n,   1);
      chk("rst_busy",    busy,        0);
      chk("rst_owner",   owner,       0);
      chk("rst_sram_a",  sram_a,      0);
      chk("rst_a_ack",   a_bus.ack,   0);
      chk("rst_b_ack",   b_bus.ack,   0);
      chk("rst_a_rdata", a_bus.rdata, 0);
      chk("rst_b_rdata", b_bus.rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // A writes 0x55 to the top address, then reads it back
      cnt0 = we_low_cnt;
      drv(0, 1'b1, 1'b1, 19'h7FFFF, 8'h55);
      wait_ack(0, lat);
      chk("a_wr_lat",    lat, 3);
      chk("a_wr_addr",   sram_a, 19'h7FFFF);
      drop(0);
      @(negedge clk);
      chk("a_wr_strobe", we_low_cnt - cnt0, 1);
      drv(0, 1'b1, 1'b0, 19'h7FFFF, 8'h00);
      wait_ack(0, lat);
      chk("a_rd_lat",    lat, 2);
      chk("a_rd_data",   a_bus.rdata, 8'h55);
      drop(0);
      @(negedge clk);

      // B back-to-back reads of 0,1,2 with inputs changed in the ack cycle
      ackq.delete();
      drv(1, 1'b1, 1'b0, 19'h00000, 8'h00);
      for (int i = 0; i < 3; i++) begin
         wait_ack(1, lat);
         chk($sformatf("b_b2b_lat%0d", i), lat, 2);
         exp_b = pat(AW'(i));
         chk($sformatf("b_b2b_data%0d", i), b_bus.rdata, exp_b);
         if (i < 2) drv(1, 1'b1, 1'b0, AW'(i + 1), 8'h00);
      end
      drop(1);
      repeat (3) @(negedge clk);
      chk("b_b2b_count", ackq.size(), 3);

      // Both ports requesting continuously
      last = 1;
      ackq.delete();
      fork
         run_port(0, 6, 0, 50);
         run_port(1, 6, 0, 50);
      join
      repeat (3) @(negedge clk);
      chk("both_count", ackq.size(), 12);
      for (int i = 0; i < 12 && i < ackq.size(); i++) begin
`ifdef SRAM_ARB_RR_EN
         chk($sformatf("both_seq%0d", i), ackq[i], (last ^ 1) ^ (i % 2));
`else
         chk($sformatf("both_seq%0d", i), ackq[i], (i < 6) ? 0 : 1);
`endif
      end

      // B pulses req for one cycle during A's write: never served
      ackq.delete();
      drv(0, 1'b1, 1'b1, 19'h00040, 8'hC3);
      @(negedge clk);
      chk("wr_busy", busy, 1);
      drv(1, 1'b1, 1'b0, 19'h00005, 8'h00);
      @(negedge clk);
      drop(1);
      wait_ack(0, lat);
      drop(0);
      repeat (4) @(negedge clk);
      chk("withdraw_acks", ackq.size(), 1);
      if (ackq.size() > 0) chk("withdraw_port", ackq[0], 0);

      // Reset in the middle of the write strobe
      ackq.delete();
      drv(0, 1'b1, 1'b1, 19'h00123, 8'hEE);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!sram_we_n) break;
      end
      chk("mid_we_low", sram_we_n, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we_n",  sram_we_n, 1);
      chk("mid_rst_busy",  busy,      0);
      chk("mid_rst_a_ack", a_bus.ack, 0);
      chk("mid_rst_sramA", sram_a,    0);
      chk("mid_rst_owner", owner,     0);
      drop(0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_post_busy", busy, 0);
      chk("mid_no_ack", ackq.size(), 0);
      drv(0, 1'b1, 1'b0, 19'h00123, 8'h00);
      wait_ack(0, lat);
      chk("mid_lost_write", a_bus.rdata, pat(19'h00123));
      drop(0);
      @(negedge clk);

      // Randomized mixed traffic on both ports
      fork
         run_port(0, 40, 4, 40);
         run_port(1, 40, 4, 40);
      join
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the board's external 512K×8 asynchronous SRAM. It lets two independent requesters share one SRAM bus. Port A is the primary master (e.g. the CPU core). Port B is the secondary master (e.g. the RAM test engine or video fetch). The block sits between those masters and the top-level SRAM pins. It generates the same single-strobe read and write sequences the board already uses, and returns one-cycle acknowledges with read data.

## Interface
Parameters:
- AW, 19, SRAM address width
- DW, 8, SRAM data width

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request (level)
- a_we  in  1  port A access type: 1 = write, 0 = read
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_rdata  out  DW  port A read data, valid while a_ack = 1
- a_ack  out  1  port A one-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: same as port A, for port B
- sram_a  out  AW  SRAM address pins (registered)
- sram_d  inout  DW  SRAM data pins; driven only while sram_we_n = 0, otherwise high-Z
- sram_we_n  out  1  SRAM write enable, active low (registered)
- busy  out  1  1 while any state other than IDLE is active
- owner  out  1  port of the current or last granted transaction (0 = A, 1 = B)

## Operation
- FSM states: IDLE, RD, WR_LO, WR_HI.
- IDLE, no request: hold everything. sram_we_n = 1, bus is high-Z.
- IDLE, request present: pick the winner and register sram_a ← addr, write data ← wdata, owner ← winner.
  - Winner's we = 0: go to RD.
  - Winner's we = 1: go to WR_LO.
- RD: capture sram_d into the owner's rdata, set the owner's ack, go to IDLE.
- WR_LO: sram_we_n ← 0, go to WR_HI.
- WR_HI: sram_we_n ← 1, set the owner's ack, go to IDLE.
- ack is a single-cycle pulse. rdata holds its value until the next read on that port.
- Handshake rules:
  - The requester holds req, we, addr and wdata stable from assertion until its ack.
  - The FSM is in IDLE during the ack cycle and samples req there. A requester that keeps req high in its ack cycle is issuing a back-to-back request, and its inputs must already carry the new transaction.
  - A requester that wants no further access drops req in its ack cycle.
- Arbitration is evaluated only in IDLE. The transaction in progress is never preempted.
- Default priority is fixed: A wins whenever a_req = 1.
- A request withdrawn before grant is simply not served. This is legal, and no ack is issued.
- Addresses are not checked. sram_a takes any AW-bit value; there is no wrap or increment logic.

## Timing
- Read: req sampled at edge 0 → sram_a valid from edge 1 → sram_d sampled at edge 2 → ack = 1 in cycle 2–3. Latency is 2 clocks req→ack, and a read occupies the bus for 1 cycle.
- Write: req sampled at edge 0 → sram_a and data registered at edge 1 → sram_we_n = 0 for one cycle (edges 2–3) → ack = 1 after edge 3. Latency is 3 clocks.
- Address is stable for at least one full cycle before sram_we_n falls, and after it rises.
- Back-to-back sustained throughput:
  - Reads: 1 per 2 clocks.
  - Writes: 1 per 3 clocks.
- Reset values (asynchronous on rst_n = 0, any state, including mid-write):
  - State = IDLE.
  - sram_we_n = 1 immediately; sram_d high-Z.
  - sram_a = 0.
  - a_ack = b_ack = 0.
  - a_rdata = b_rdata = 0.
  - busy = 0; owner = 0.
- An interrupted write is lost and no ack is issued.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the port that did not win the previous grant wins.
  - A lone requester always wins.
  - Neither port waits more than one foreign transaction.
- Undefined: fixed priority, A over B. Continuous A requests may starve B indefinitely; this is accepted.

## Test plan
- Reset mid-write: assert rst_n = 0 while sram_we_n = 0 → sram_we_n = 1 and sram_d = Z in the same cycle; no ack; after release, state is IDLE with busy = 0.
- Single A write then read:
  - A writes 0x55 to 0x7FFFF → sram_a = 0x7FFFF, sram_we_n low exactly one cycle, a_ack 3 clocks after req.
  - A then reads 0x7FFFF → a_rdata = 0x55 with a_ack 2 clocks after req.
- Simultaneous a_req/b_req with SRAM_ARB_RR_EN undefined, both held → A served every transaction; b_ack never seen while A keeps requesting.
- Simultaneous continuous requests with SRAM_ARB_RR_EN defined → acks alternate A, B, A, B; owner toggles each grant.
- B back-to-back reads of 0x00000, 0x00001, 0x00002 (req held through ack, inputs changed on the ack cycle) → three b_ack pulses 2 clocks apart with the correct data; no duplicated access.
- B raises b_req for one cycle while A's write is in progress, then drops it → no B access and no b_ack; sram_d is never driven outside the sram_we_n = 0 cycle.
